// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyphs (bit order dp,g,f,e,d,c,b,a) and scroll modes.
package seg7_pkg;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_H     = 8'h89;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_L     = 8'hC7;
    localparam logic [7:0] GLYPH_O     = 8'hC0;
    localparam logic [7:0] GLYPH_W     = 8'hC1;
    localparam logic [7:0] GLYPH_R     = 8'hAF;
    localparam logic [7:0] GLYPH_D     = 8'hA1;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_BOUNCE  = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    // Hex digit 0-F to active-low glyph
    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_msg_scroller_if.sv
// Control/write/display bundle between board control logic and the message scroller.
interface hex_msg_scroller_if #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_DEPTH  = 32
);
    localparam int unsigned AW = $clog2(MSG_DEPTH);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [7:0]              wr_data;
    logic                    load;
    logic [AW:0]             len_in;
    logic [1:0]              mode;
    logic                    dir;
    logic                    pause;
    logic [NUM_DIGITS*8-1:0] hex_out;
    logic [AW-1:0]           index_out;
    logic                    done;

    modport master (
        output wr_en, wr_addr, wr_data, load, len_in, mode, dir, pause,
        input  hex_out, index_out, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load, len_in, mode, dir, pause,
        output hex_out, index_out, done
    );
endinterface

// File: rtl/hex_msg_scroller_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks (DIV >= 2).
module tick_gen #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nx_c;

    assign cnt_nx_c = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);

    // tick is registered so it is high exactly while the counter holds DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_nx_c;
            tick  <= (cnt_nx_c == CW'(DIV - 1));
        end
    end
endmodule

// File: rtl/hex_msg_scroller.sv
// Writable glyph buffer scrolled across NUM_DIGITS active-low 7-seg digits (wrap/bounce/one-shot).
module hex_msg_scroller
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_DEPTH  = 32,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter logic [7:0]  BLANK      = GLYPH_BLANK
) (
    input  logic            MAX10_CLK1_50,
    input  logic            reset,
    hex_msg_scroller_if.slave bus
);
    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned HW = NUM_DIGITS * 8;

    localparam logic [0:0] ST_SCROLL = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic          tick;
    logic [7:0]    msg_buf [MSG_DEPTH];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    mode_q, mode_d;
    logic          bdir_q, bdir_d;
    logic          done_q, done_d;
    logic [HW-1:0] hex_q, hex_d;

    logic [LW-1:0] len_clamp_c;
    logic [AW-1:0] last_c;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (MAX10_CLK1_50),
        .rst  (reset),
        .tick (tick)
    );

    // Buffer is intentionally not reset; out-of-range addresses are dropped
    always_ff @(posedge MAX10_CLK1_50) begin
        if (bus.wr_en && (LW'(bus.wr_addr) < LW'(MSG_DEPTH)))
            msg_buf[bus.wr_addr] <= bus.wr_data;
    end

    assign len_clamp_c = (bus.len_in > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : bus.len_in;
    assign last_c      = (len_q == '0) ? '0 : AW'(len_q - LW'(1));

    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCROLL;
            idx_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_WRAP;
            bdir_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {NUM_DIGITS{BLANK}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            bdir_q  <= bdir_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    // Index FSM: load wins over tick; one-shot halts the cycle after reaching its terminal index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mode_d  = mode_q;
        bdir_d  = bdir_q;
        done_d  = 1'b0;
        if (bus.load) begin
            len_d   = len_clamp_c;
            mode_d  = bus.mode;
            bdir_d  = bus.dir;
            idx_d   = (bus.dir && len_clamp_c != '0) ? AW'(len_clamp_c - LW'(1)) : '0;
            state_d = ST_SCROLL;
        end else begin
            case (state_q)
                ST_SCROLL: begin
                    if (mode_q == MODE_ONESHOT && len_q != '0 &&
                        idx_q == (bus.dir ? '0 : last_c)) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else if (tick && !bus.pause && len_q != '0) begin
                        if (mode_q == MODE_BOUNCE) begin
                            if (len_q == LW'(1)) begin
                                idx_d = '0;
                            end else if (!bdir_q) begin
                                if (idx_q == last_c) begin
                                    bdir_d = 1'b1;
                                    idx_d  = idx_q - AW'(1);
                                end else begin
                                    idx_d  = idx_q + AW'(1);
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    bdir_d = 1'b0;
                                    idx_d  = idx_q + AW'(1);
                                end else begin
                                    idx_d  = idx_q - AW'(1);
                                end
                            end
                        end else if (bus.dir) begin
                            idx_d = (idx_q == '0) ? last_c : idx_q - AW'(1);
                        end else begin
                            idx_d = (idx_q == last_c) ? '0 : idx_q + AW'(1);
                        end
                    end
                end
                ST_HALTED: ;
                default: state_d = ST_SCROLL;
            endcase
        end
    end

    // Digit k shows buf[index-k] while that offset lies inside the message
    always_comb begin
        hex_d = {NUM_DIGITS{BLANK}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx_q) >= k && (int'(idx_q) - k) < int'(len_q))
                hex_d[8*k +: 8] = msg_buf[AW'(int'(idx_q) - k)];
        end
    end

    assign bus.hex_out   = hex_q;
    assign bus.index_out = idx_q;
    assign bus.done      = done_q;
endmodule
